// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, register-file sequencer states and
// the hard-wired zero register index.
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    ISSUE,
    WAIT_RES,
    WB
  } seq_state_t;

endpackage

// File: rtl/regfile_sequencer.sv
// Multi-cycle register-file sequencer: reads rs1/rs2 over the shared bus, hands
// operands to execute, writes the result back. Optional x0 read bypass when
// REGFILE_SEQ_X0_BYPASS_EN is defined.
module regfile_sequencer #(
  parameter int XLEN       = cpu_pkg::XLEN,
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd_idx,
  input  logic                  wb_en,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [XLEN-1:0]       op_a,
  output logic [XLEN-1:0]       op_b,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic [XLEN-1:0]       res_data,
  output logic                  rf_rd,
  output logic                  rf_wr,
  output logic [REG_ADDR_W-1:0] rf_addr,
  inout  wire  [XLEN-1:0]       bus
);

  import cpu_pkg::*;

  localparam logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(REG_ZERO);

  seq_state_t            state_q, state_d;
  logic [REG_ADDR_W-1:0] rs1_q, rs1_d;
  logic [REG_ADDR_W-1:0] rs2_q, rs2_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  wb_en_q, wb_en_d;
  logic [XLEN-1:0]       op_a_q, op_a_d;
  logic [XLEN-1:0]       op_b_q, op_b_d;
  logic [XLEN-1:0]       res_q, res_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      wb_en_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      wb_en_q <= wb_en_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    wb_en_d = wb_en_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    res_d   = res_q;

    case (state_q)
      IDLE: begin
        if (start_valid) begin
          rs1_d   = rs1;
          rs2_d   = rs2;
          rd_d    = rd_idx;
          wb_en_d = wb_en;
`ifdef REGFILE_SEQ_X0_BYPASS_EN
          // x0 operands are known to be zero, so their bus reads are skipped.
          if (rs1 == ZERO_IDX) begin
            op_a_d = '0;
            if (rs2 == ZERO_IDX) begin
              op_b_d  = '0;
              state_d = ISSUE;
            end else begin
              state_d = RD_B;
            end
          end else begin
            state_d = RD_A;
          end
`else
          state_d = RD_A;
`endif
        end
      end
      RD_A: begin
        op_a_d = bus;
`ifdef REGFILE_SEQ_X0_BYPASS_EN
        if (rs2_q == ZERO_IDX) begin
          op_b_d  = '0;
          state_d = ISSUE;
        end else begin
          state_d = RD_B;
        end
`else
        state_d = RD_B;
`endif
      end
      RD_B: begin
        op_b_d  = bus;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (op_ready) state_d = WAIT_RES;
      end
      WAIT_RES: begin
        if (res_valid) begin
          res_d   = res_data;
          state_d = (wb_en_q && (rd_q != ZERO_IDX)) ? WB : IDLE;
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    start_ready = 1'b0;
    op_valid    = 1'b0;
    res_ready   = 1'b0;
    rf_rd       = 1'b0;
    rf_wr       = 1'b0;
    rf_addr     = '0;

    case (state_q)
      IDLE:     start_ready = 1'b1;
      RD_A: begin
        rf_rd   = 1'b1;
        rf_addr = rs1_q;
      end
      RD_B: begin
        rf_rd   = 1'b1;
        rf_addr = rs2_q;
      end
      ISSUE:    op_valid  = 1'b1;
      WAIT_RES: res_ready = 1'b1;
      WB: begin
        rf_wr   = 1'b1;
        rf_addr = rd_q;
      end
      default:  start_ready = 1'b0;
    endcase
  end

  // Only WB drives the bus; reset forces IDLE asynchronously, releasing it at once.
  assign bus    = (state_q == WB) ? res_q : {XLEN{1'bz}};
  assign op_a   = op_a_q;
  assign op_b   = op_b_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench for regfile_sequencer with a register-file model on the
// shared bus and a scoreboard of expected operands and writebacks.
module tb_regfile_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd_idx;
  logic        wb_en;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        rf_rd;
  logic        rf_wr;
  logic [4:0]  rf_addr;
  wire  [31:0] bus;

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wb;
    logic [31:0] res;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    int          op_stall;
    int          res_stall;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } op_exp_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_exp_t;

  vec_t        vecs [9];
  op_exp_t     op_q [$];
  wr_exp_t     wr_q [$];
  logic [31:0] rf_mem [32] = '{default: 32'h0};

  int checks;
  int failures;
  int rd_total;
  int wr_total;
  int contention;

  regfile_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd_idx      (rd_idx),
    .wb_en       (wb_en),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .rf_rd       (rf_rd),
    .rf_wr       (rf_wr),
    .rf_addr     (rf_addr),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: drives the bus on reads, captures it on writes, x0 stays zero.
  assign bus = rf_rd ? rf_mem[rf_addr] : {32{1'bz}};

  always @(posedge clk) begin
    if (rf_wr && (rf_addr != 5'd0)) rf_mem[rf_addr] <= bus;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int expRdPulses(input logic [4:0] a, input logic [4:0] b);
`ifdef REGFILE_SEQ_X0_BYPASS_EN
    return ((a != 5'd0) ? 1 : 0) + ((b != 5'd0) ? 1 : 0);
`else
    return 2;
`endif
  endfunction

  task automatic waitIdle(input string name);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!start_ready && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (!start_ready) checkOutput(name, 32'(start_ready), 32'd1);
  endtask

  task automatic applyStimulus(input vec_t v);
    int   cnt;
    int   guard;
    int   rd0;
    int   wr0;
    logic done;
    logic exp_wr;
    exp_wr = v.wb && (v.rd != 5'd0);
    waitIdle("idle_timeout");
    @(posedge clk); #1;
    rs1         = v.rs1;
    rs2         = v.rs2;
    rd_idx      = v.rd;
    wb_en       = v.wb;
    res_data    = v.res;
    op_ready    = 1'b0;
    res_valid   = 1'b0;
    op_q.push_back('{a: v.exp_a, b: v.exp_b});
    if (exp_wr) wr_q.push_back('{addr: v.rd, data: v.res});
    rd0         = rd_total;
    wr0         = wr_total;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    rs1         = 5'h1f;
    rs2         = 5'h1f;
    rd_idx      = 5'h1f;

    cnt = 0; guard = 0; done = 1'b0;
    while (!done && guard < 100) begin
      if (op_valid && cnt >= v.op_stall) begin
        op_ready = 1'b1;
        @(posedge clk); #1;
        op_ready = 1'b0;
        done     = 1'b1;
      end else begin
        if (op_valid) cnt++;
        @(posedge clk); #1;
      end
      guard++;
    end
    if (!done) checkOutput("op_timeout", 32'd0, 32'd1);

    cnt = 0; guard = 0; done = 1'b0;
    while (!done && guard < 100) begin
      if (res_ready && cnt >= v.res_stall) begin
        res_valid = 1'b1;
        @(posedge clk); #1;
        res_valid = 1'b0;
        done      = 1'b1;
      end else begin
        if (res_ready) begin
          cnt++;
          checkOutput("wait_start_ready", 32'(start_ready), 32'd0);
        end
        @(posedge clk); #1;
      end
      guard++;
    end
    if (!done) checkOutput("res_timeout", 32'd0, 32'd1);

    @(negedge clk);
    checkOutput("post_res_start_ready", 32'(start_ready), 32'(!exp_wr));
    waitIdle("wb_idle_timeout");
    checkOutput("rd_pulses", 32'(rd_total - rd0), 32'(expRdPulses(v.rs1, v.rs2)));
    checkOutput("wr_pulses", 32'(wr_total - wr0), 32'(exp_wr));
  endtask

  initial begin
    int          k_op;
    int          k_wr;
    int          k_idle;
    int          rd0;
    int          exp_k_op;
    logic        hold_prev;
    logic [31:0] prev_a;
    logic [31:0] prev_b;

    checks      = 0;
    failures    = 0;
    rd_total    = 0;
    wr_total    = 0;
    contention  = 0;
    rst_n       = 1'b0;
    start_valid = 1'b0;
    rs1         = 5'd0;
    rs2         = 5'd0;
    rd_idx      = 5'd0;
    wb_en       = 1'b0;
    op_ready    = 1'b0;
    res_valid   = 1'b0;
    res_data    = 32'd0;
    hold_prev   = 1'b0;
    prev_a      = 32'd0;
    prev_b      = 32'd0;

    vecs[0] = '{5'd0, 5'd0, 5'd3, 1'b1, 32'h12345678, 32'h00000000, 32'h00000000, 0, 0};
    vecs[1] = '{5'd3, 5'd0, 5'd5, 1'b0, 32'h00000001, 32'h12345678, 32'h00000000, 1, 0};
    vecs[2] = '{5'd0, 5'd0, 5'd0, 1'b1, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 0, 2};
    vecs[3] = '{5'd0, 5'd3, 5'd7, 1'b1, 32'hA5A5A5A5, 32'h00000000, 32'h12345678, 0, 0};
    vecs[4] = '{5'd7, 5'd7, 5'd1, 1'b1, 32'h0F0F0F0F, 32'hA5A5A5A5, 32'hA5A5A5A5, 4, 3};
    vecs[5] = '{5'd1, 5'd3, 5'd3, 1'b1, 32'hCAFEF00D, 32'h0F0F0F0F, 32'h12345678, 0, 0};
    vecs[6] = '{5'd3, 5'd1, 5'd0, 1'b0, 32'h00000000, 32'hCAFEF00D, 32'h0F0F0F0F, 0, 1};
    vecs[7] = '{5'd9, 5'd1, 5'd2, 1'b1, 32'h13579BDF, 32'h00000000, 32'h0F0F0F0F, 0, 0};
    vecs[8] = '{5'd2, 5'd11, 5'd0, 1'b1, 32'h00000000, 32'h13579BDF, 32'h55AA55AA, 0, 0};

    // Scoreboard/monitor runs inside this process tree, sampling on the falling edge.
    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (rf_rd) rd_total++;
          if (rf_wr) wr_total++;
          if (rf_rd && rf_wr) contention++;
          if (op_valid && hold_prev) begin
            checkOutput("hold_op_a", op_a, prev_a);
            checkOutput("hold_op_b", op_b, prev_b);
            checkOutput("hold_start_ready", 32'(start_ready), 32'd0);
          end
          hold_prev = op_valid && !op_ready;
          prev_a    = op_a;
          prev_b    = op_b;
          if (op_valid && op_ready) begin
            if (op_q.size() == 0) begin
              checkOutput("op_unexpected", 32'd1, 32'd0);
            end else begin
              op_exp_t e;
              e = op_q.pop_front();
              checkOutput("op_a", op_a, e.a);
              checkOutput("op_b", op_b, e.b);
            end
          end
          if (rf_wr) begin
            if (wr_q.size() == 0) begin
              checkOutput("wr_unexpected", 32'(rf_addr), 32'hFFFFFFFF);
            end else begin
              wr_exp_t w;
              w = wr_q.pop_front();
              checkOutput("wb_addr", 32'(rf_addr), 32'(w.addr));
              checkOutput("wb_data", bus, w.data);
            end
          end
        end
      end
    join_none

    #2;
    checkOutput("rst_start_ready", 32'(start_ready), 32'd1);
    checkOutput("rst_op_valid", 32'(op_valid), 32'd0);
    checkOutput("rst_res_ready", 32'(res_ready), 32'd0);
    checkOutput("rst_rf_rd", 32'(rf_rd), 32'd0);
    checkOutput("rst_rf_wr", 32'(rf_wr), 32'd0);
    checkOutput("rst_rf_addr", 32'(rf_addr), 32'd0);
    checkOutput("rst_op_a", op_a, 32'd0);
    checkOutput("rst_op_b", op_b, 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);
    checkOutput("mem_r3", rf_mem[3], 32'hCAFEF00D);
    checkOutput("mem_r7", rf_mem[7], 32'hA5A5A5A5);
    checkOutput("mem_r5_untouched", rf_mem[5], 32'h0);
    checkOutput("mem_r0", rf_mem[0], 32'h0);

    // Minimum-latency run with both execute handshakes already high.
    waitIdle("lat_idle_timeout");
    @(posedge clk); #1;
    rs1 = 5'd0; rs2 = 5'd0; rd_idx = 5'd11; wb_en = 1'b1; res_data = 32'h55AA55AA;
    op_ready = 1'b1; res_valid = 1'b1; start_valid = 1'b1;
    op_q.push_back('{a: 32'h0, b: 32'h0});
    wr_q.push_back('{addr: 5'd11, data: 32'h55AA55AA});
    rd0 = rd_total;
    @(posedge clk); #1;
    start_valid = 1'b0;
    k_op = -1; k_wr = -1; k_idle = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (op_valid && k_op < 0) k_op = k;
      if (rf_wr && k_wr < 0) k_wr = k;
      if (start_ready && k_idle < 0) k_idle = k;
      @(posedge clk); #1;
    end
    op_ready = 1'b0; res_valid = 1'b0;
`ifdef REGFILE_SEQ_X0_BYPASS_EN
    exp_k_op = 0;
`else
    exp_k_op = 2;
`endif
    checkOutput("lat_op_valid", 32'(k_op), 32'(exp_k_op));
    checkOutput("lat_wb", 32'(k_wr), 32'(exp_k_op + 2));
    checkOutput("lat_idle", 32'(k_idle), 32'(exp_k_op + 3));
    checkOutput("lat_rd_pulses", 32'(rd_total - rd0), 32'(expRdPulses(5'd0, 5'd0)));
    checkOutput("mem_r11", rf_mem[11], 32'h55AA55AA);

    // Reset asserted while reading rs2.
    waitIdle("rdb_idle_timeout");
    @(posedge clk); #1;
    rs1 = 5'd1; rs2 = 5'd3; rd_idx = 5'd4; wb_en = 1'b1; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    checkOutput("rdb_seq_rd_a", 32'(rf_addr), 32'd1);
    @(posedge clk); #1;
    checkOutput("rdb_seq_rd_b", 32'(rf_addr), 32'd3);
    checkOutput("rdb_seq_rf_rd", 32'(rf_rd), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rdb_rst_rf_rd", 32'(rf_rd), 32'd0);
    checkOutput("rdb_rst_rf_wr", 32'(rf_wr), 32'd0);
    checkOutput("rdb_rst_start_ready", 32'(start_ready), 32'd1);
    checkOutput("rdb_rst_op_a", op_a, 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    op_q.delete();
    wr_q.delete();
    hold_prev = 1'b0;
    checkOutput("rdb_mem_r4", rf_mem[4], 32'h0);

    // Reset asserted during the writeback cycle, before its edge.
    waitIdle("wb_rst_idle_timeout");
    @(posedge clk); #1;
    rs1 = 5'd1; rs2 = 5'd3; rd_idx = 5'd9; wb_en = 1'b1; res_data = 32'h77777777;
    op_ready = 1'b1; res_valid = 1'b1; start_valid = 1'b1;
    op_q.push_back('{a: 32'h0F0F0F0F, b: 32'hCAFEF00D});
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("wbr_rf_wr", 32'(rf_wr), 32'd1);
    checkOutput("wbr_rf_addr", 32'(rf_addr), 32'd9);
    checkOutput("wbr_bus", bus, 32'h77777777);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("wbr_rst_rf_wr", 32'(rf_wr), 32'd0);
    checkOutput("wbr_rst_rf_rd", 32'(rf_rd), 32'd0);
    checkOutput("wbr_rst_start_ready", 32'(start_ready), 32'd1);
    checkOutput("wbr_rst_op_a", op_a, 32'd0);
    checkOutput("wbr_rst_op_b", op_b, 32'd0);
    op_ready = 1'b0; res_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    op_q.delete();
    wr_q.delete();
    hold_prev = 1'b0;
    checkOutput("wbr_mem_r9", rf_mem[9], 32'h0);

    for (int i = 7; i < 9; i++) applyStimulus(vecs[i]);
    checkOutput("mem_r2", rf_mem[2], 32'h13579BDF);

    checkOutput("contention", 32'(contention), 32'd0);
    checkOutput("op_q_drained", 32'(op_q.size()), 32'd0);
    checkOutput("wr_q_drained", 32'(wr_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
